// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
//
// Compares two WIDTH-bit operands DIGIT bits per clock, starting with the most
// significant digit. A registered greater/equal cascade carries the running
// result. Signed operands are handled by flipping the sign bit, which maps
// two's-complement ordering onto unsigned ordering.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted only while busy=0
//   signed_mode in   1 = two's-complement compare, sampled with start
//   a, b        in   operands, sampled with start
//   busy        out  compare in progress
//   done        out  one-cycle pulse, result valid
//   gt, eq, lt  out  registered result, held until the next completion
module seq_magnitude_comparator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGIT      = 4,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_g;
    logic             r_e;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;

    logic [31:0]      w_shamt;
    logic [WIDTH-1:0] w_sh_a;
    logic [WIDTH-1:0] w_sh_b;
    logic [DIGIT-1:0] w_dig_a;
    logic [DIGIT-1:0] w_dig_b;
    logic             w_g_next;
    logic             w_e_next;
    logic             w_last;

    // Shift the current digit up to the top so a fixed slice picks it out.
    assign w_shamt  = {{(32 - CNT_W){1'b0}}, r_cnt} * DIGIT;
    assign w_sh_a   = r_a << w_shamt;
    assign w_sh_b   = r_b << w_shamt;
    assign w_dig_a  = w_sh_a[WIDTH-1 -: DIGIT];
    assign w_dig_b  = w_sh_b[WIDTH-1 -: DIGIT];

    // Only the first unequal digit can set g; once e drops, g is frozen.
    assign w_g_next = r_g | (r_e & (w_dig_a > w_dig_b));
    assign w_e_next = r_e & (w_dig_a == w_dig_b);

    always_comb begin
        w_state_next = r_state;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                w_last = (r_cnt == LAST_CNT) | (EARLY_EXIT & ~w_e_next);
                if (w_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_g     <= 1'b0;
            r_e     <= 1'b1;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            if (r_state == StIdle) begin
                if (start) begin
                    // Offset-binary: flipping the sign bit makes signed order unsigned.
                    r_a   <= signed_mode ? (a ^ MSB_MASK) : a;
                    r_b   <= signed_mode ? (b ^ MSB_MASK) : b;
                    r_g   <= 1'b0;
                    r_e   <= 1'b1;
                    r_cnt <= '0;
                end
            end else begin
                r_g   <= w_g_next;
                r_e   <= w_e_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_gt   <= w_g_next;
                    r_eq   <= w_e_next;
                    r_lt   <= ~w_g_next & ~w_e_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == StRun);
    assign done = r_done;
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule
